instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Front end that drives the register-file/ALU datapath: reads R-type RV32I instructions from an instruction memory over a req/ack handshake, decodes them, and drives the datapath's read_reg_num1/2, write_reg, alu_control and regwrite.
- Sequencing accounts for the datapath registering its control inputs one clock before use.
- Stops on ecall or any unsupported encoding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- start  input  1  begin fetching; sampled only in IDLE.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address (= pc).
- imem_ack  input  1  memory response valid; imem_rdata sampled on this cycle.
- imem_rdata  input  32  instruction word.
- read_reg_num1  output  5  rs1 to datapath.
- read_reg_num2  output  5  rs2 to datapath.
- write_reg  output  5  rd to datapath.
- alu_control  output  4  ALU operation code.
- regwrite  output  1  register write enable to datapath.
- pc  output  32  current program counter.
- busy  output  1  high in FETCH/ISSUE/EXEC.
- halted  output  1  high in HALT.
- illegal  output  1  sticky; set when halt was caused by an unsupported instruction.
- retired  output  CNT_W  count of issued R-type instructions, saturating at all-ones.

Behaviour:
- Reset values: state IDLE, pc=RESET_PC, imem_req=0, all register numbers 0, alu_control=0, regwrite=0, busy=0, halted=0, illegal=0, retired=0. Reset mid-fetch drops imem_req the same instant; a late ack after reset is ignored.
- FSM states: IDLE, FETCH, ISSUE, EXEC, HALT.
  - IDLE: start=1 -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc held stable until ack.
    - On imem_ack=1, imem_rdata is latched into the instruction register and imem_req deasserts next cycle.
    - Next state: ISSUE if the word is supported R-type; HALT otherwise.
  - ISSUE, one cycle: read_reg_num1=rs1, read_reg_num2=rs2, write_reg=rd, alu_control=decoded code, regwrite=1 unless rd==0 (then 0). Also pc<=pc+4 (modulo 2^32 wrap), retired<=retired+1 (saturating). Next state EXEC.
  - EXEC, one cycle: regwrite=0, alu_control=0. read_reg_num1/2 and write_reg hold the ISSUE values, because the datapath uses registered control plus live read ports this cycle. Next state FETCH.
  - HALT: every output holds except regwrite=0 and imem_req=0. Only reset leaves HALT; start is ignored.
- Throughput: one instruction per 3 cycles plus memory latency. With zero-wait ack (ack in the first FETCH cycle), the sequence is FETCH, ISSUE, EXEC per instruction.
- Decode: supported only when opcode[6:0]=0110011 and funct7 is 0000000, or is 0100000 for funct3 000 or 101.
  - alu_control map (funct7 bit5, funct3):
    - add 0010, sub 0100
    - sll 0011, slt 1000, sltu 1001, xor 0110
    - srl 0101, sra 0111
    - or 0001, and 0000
- Halt causes:
  - 32'h0000_0073 (ecall) -> HALT with illegal=0.
  - Any other unsupported word -> HALT with illegal=1.
  - Neither case increments retired or pc.
- start asserted outside IDLE has no effect. imem_ack outside FETCH is ignored.

Test Plan:
- Reset, start, zero-wait ack with 32'h002081B3 (add x3,x1,x2) -> ISSUE cycle shows rs1=1, rs2=2, rd=3, alu_control=0010, regwrite=1. EXEC shows regwrite=0 with rs1/rs2 held. Then pc=4, retired=1.
- Fetch 32'h407302B3 (sub x5,x6,x7) with ack delayed 3 cycles -> imem_req high for 4 cycles with imem_addr constant. Then alu_control=0100, rd=5.
- 32'h00208033 (add x0,x1,x2) -> alu_control=0010, regwrite stays 0, retired still increments.
- Program add, ecall -> after ecall: halted=1, illegal=0, pc=4, retired=1, imem_req=0. A later start pulse gives no new request.
- 32'h00000013 (addi) -> halted=1, illegal=1, retired=0. Assert reset -> all outputs return to reset values, pc=RESET_PC.
- Assert reset while FETCH awaits ack -> imem_req=0 immediately. An ack arriving after reset causes no state change (stays IDLE).

Source files
------------

// File: rtl/instr_fetch_decode.sv
// R-type RV32I fetch/decode front end for the register-file/ALU datapath.
// Control fields are registered into ISSUE and held through EXEC for the datapath's live read ports.
module instr_fetch_decode #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [4:0]       read_reg_num1,
   output logic [4:0]       read_reg_num2,
   output logic [4:0]       write_reg,
   output logic [3:0]       alu_control,
   output logic             regwrite,
   output logic [31:0]      pc,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_pc;
   logic [4:0]       r_rs1;
   logic [4:0]       r_rs2;
   logic [4:0]       r_rd;
   logic [3:0]       r_alu;
   logic             r_regwrite;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired;

   logic [6:0]       w_opcode;
   logic [2:0]       w_funct3;
   logic [6:0]       w_funct7;
   logic             w_supported;
   logic [3:0]       w_alu;
   logic             w_ecall;
   logic             w_req;
   logic             w_busy;
   logic             w_halted;

   assign w_opcode = imem_rdata[6:0];
   assign w_funct3 = imem_rdata[14:12];
   assign w_funct7 = imem_rdata[31:25];
   assign w_ecall  = (imem_rdata == 32'h0000_0073);

   always_comb begin
      w_supported = 1'b0;
      w_alu       = '0;
      if (w_opcode == 7'b0110011) begin
         if (w_funct7 == 7'b0000000) begin
            w_supported = 1'b1;
            case (w_funct3)
               3'b000:  w_alu = 4'b0010;
               3'b001:  w_alu = 4'b0011;
               3'b010:  w_alu = 4'b1000;
               3'b011:  w_alu = 4'b1001;
               3'b100:  w_alu = 4'b0110;
               3'b101:  w_alu = 4'b0101;
               3'b110:  w_alu = 4'b0001;
               default: w_alu = 4'b0000;
            endcase
         end else if (w_funct7 == 7'b0100000) begin
            if (w_funct3 == 3'b000) begin
               w_supported = 1'b1;
               w_alu       = 4'b0100;
            end else if (w_funct3 == 3'b101) begin
               w_supported = 1'b1;
               w_alu       = 4'b0111;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_req    = 1'b0;
      w_busy   = 1'b0;
      w_halted = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_next = S_FETCH;
         S_FETCH: begin
            w_req  = 1'b1;
            w_busy = 1'b1;
            if (imem_ack) w_next = w_supported ? S_ISSUE : S_HALT;
         end
         S_ISSUE: begin
            w_busy = 1'b1;
            w_next = S_EXEC;
         end
         S_EXEC: begin
            w_busy = 1'b1;
            w_next = S_FETCH;
         end
         S_HALT:  w_halted = 1'b1;
         default: w_next = S_IDLE;
      endcase
   end

   // Fields load on the ack so they are already valid during ISSUE; ISSUE clears regwrite/alu for EXEC.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_alu      <= '0;
         r_regwrite <= 1'b0;
         r_illegal  <= 1'b0;
         r_retired  <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_ack) begin
                  if (w_supported) begin
                     r_rs1      <= imem_rdata[19:15];
                     r_rs2      <= imem_rdata[24:20];
                     r_rd       <= imem_rdata[11:7];
                     r_alu      <= w_alu;
                     r_regwrite <= (imem_rdata[11:7] != 5'd0);
                  end else begin
                     r_illegal  <= !w_ecall;
                  end
               end
            end
            S_ISSUE: begin
               r_pc       <= r_pc + 32'd4;
               r_regwrite <= 1'b0;
               r_alu      <= '0;
               if (r_retired != '1) r_retired <= r_retired + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign imem_req      = w_req;
   assign imem_addr     = r_pc;
   assign pc            = r_pc;
   assign read_reg_num1 = r_rs1;
   assign read_reg_num2 = r_rs2;
   assign write_reg     = r_rd;
   assign alu_control   = r_alu;
   assign regwrite      = r_regwrite;
   assign busy          = w_busy;
   assign halted        = w_halted;
   assign illegal       = r_illegal;
   assign retired       = r_retired;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: expected ISSUE fields are queued at ack time and popped in ISSUE.
module tb_instr_fetch_decode;

   logic        clock;
   logic        reset;
   logic        start;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [4:0]  read_reg_num1;
   logic [4:0]  read_reg_num2;
   logic [4:0]  write_reg;
   logic [3:0]  alu_control;
   logic        regwrite;
   logic [31:0] pc;
   logic        busy;
   logic        halted;
   logic        illegal;
   logic [15:0] retired;

   instr_fetch_decode #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2), .write_reg(write_reg),
      .alu_control(alu_control), .regwrite(regwrite), .pc(pc), .busy(busy),
      .halted(halted), .illegal(illegal), .retired(retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [3:0] alu;
      logic       rw;
   } exp_t;

   exp_t        sb[$];
   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [31:0] m_pc;
   logic [15:0] m_ret;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   // Returns {supported, alu_control} from the R-type operation table.
   function automatic logic [4:0] ref_dec(input logic [31:0] w);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = w[14:12];
      f7 = w[31:25];
      if (w[6:0] != 7'b0110011) return 5'h00;
      if (f7 == 7'h00) begin
         case (f3)
            3'd0: return {1'b1, 4'b0010};
            3'd1: return {1'b1, 4'b0011};
            3'd2: return {1'b1, 4'b1000};
            3'd3: return {1'b1, 4'b1001};
            3'd4: return {1'b1, 4'b0110};
            3'd5: return {1'b1, 4'b0101};
            3'd6: return {1'b1, 4'b0001};
            default: return {1'b1, 4'b0000};
         endcase
      end
      if (f7 == 7'h20 && f3 == 3'd0) return {1'b1, 4'b0100};
      if (f7 == 7'h20 && f3 == 3'd5) return {1'b1, 4'b0111};
      return 5'h00;
   endfunction

   // Entered at a negedge in FETCH; leaves at a negedge in FETCH (supported) or HALT.
   task automatic issue(input logic [31:0] w, input int unsigned delay);
      logic [4:0] d;
      exp_t       e;
      d = ref_dec(w);
      for (int unsigned i = 0; i < delay; i++) begin
         chk("wait_req", imem_req, 1'b1);
         chk("wait_addr", imem_addr, m_pc);
         step();
      end
      chk("ack_req", imem_req, 1'b1);
      chk("ack_addr", imem_addr, m_pc);
      imem_ack   = 1'b1;
      imem_rdata = w;
      if (d[4]) sb.push_back('{rs1: w[19:15], rs2: w[24:20], rd: w[11:7], alu: d[3:0], rw: (w[11:7] != 5'd0)});
      step();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (d[4]) begin
         e = sb.pop_front();
         chk("iss_rs1", read_reg_num1, e.rs1);
         chk("iss_rs2", read_reg_num2, e.rs2);
         chk("iss_rd", write_reg, e.rd);
         chk("iss_alu", alu_control, e.alu);
         chk("iss_rw", regwrite, e.rw);
         chk("iss_req", imem_req, 1'b0);
         chk("iss_pc", pc, m_pc);
         step();
         m_pc = m_pc + 32'd4;
         if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
         chk("exe_rw", regwrite, 1'b0);
         chk("exe_alu", alu_control, 4'b0000);
         chk("exe_rs1", read_reg_num1, e.rs1);
         chk("exe_rs2", read_reg_num2, e.rs2);
         chk("exe_rd", write_reg, e.rd);
         chk("exe_pc", pc, m_pc);
         chk("exe_ret", retired, m_ret);
         chk("exe_busy", busy, 1'b1);
         step();
         chk("refetch_req", imem_req, 1'b1);
      end else begin
         chk("halt_halted", halted, 1'b1);
         chk("halt_busy", busy, 1'b0);
         chk("halt_req", imem_req, 1'b0);
         chk("halt_rw", regwrite, 1'b0);
         chk("halt_pc", pc, m_pc);
         chk("halt_ret", retired, m_ret);
         chk("halt_illegal", illegal, (w != 32'h0000_0073));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_pc  = 32'h0;
      m_ret = 16'h0;
      sb.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_req", imem_req, 1'b1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"}, imem_req, 1'b0);
      chk({tag, "_pc"}, pc, 32'h0);
      chk({tag, "_rs1"}, read_reg_num1, 5'd0);
      chk({tag, "_rs2"}, read_reg_num2, 5'd0);
      chk({tag, "_rd"}, write_reg, 5'd0);
      chk({tag, "_alu"}, alu_control, 4'd0);
      chk({tag, "_rw"}, regwrite, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_halted"}, halted, 1'b0);
      chk({tag, "_illegal"}, illegal, 1'b0);
      chk({tag, "_ret"}, retired, 16'd0);
   endtask

   initial begin
      logic [31:0] w;
      reset      = 1'b1;
      start      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      m_pc       = 32'h0;
      m_ret      = 16'h0;
      step();
      chk_reset_vals("rst");
      reset = 1'b0;

      pulse_start();
      issue(32'h002081B3, 0);
      issue(32'h407302B3, 3);
      issue(32'h00208033, 0);
      for (int unsigned f3 = 0; f3 < 8; f3++) begin
         w = {7'h00, 5'(f3 + 16), 5'(31 - f3), 3'(f3), 5'(f3 + 10), 7'b0110011};
         issue(w, f3 % 2);
      end
      issue({7'h20, 5'd9, 5'd4, 3'd5, 5'd17, 7'b0110011}, 1);

      // add then ecall: clean halt, start ignored afterwards
      do_reset();
      pulse_start();
      issue(32'h002081B3, 0);
      issue(32'h0000_0073, 0);
      chk("ecall_hold_rs1", read_reg_num1, 5'd1);
      chk("ecall_hold_rd", write_reg, 5'd3);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("halt_start_req", imem_req, 1'b0);
      chk("halt_start_halted", halted, 1'b1);
      chk("halt_start_pc", pc, 32'd4);

      // addi is illegal; async reset clears everything
      do_reset();
      pulse_start();
      issue(32'h0000_0013, 0);
      reset = 1'b1;
      #1;
      chk_reset_vals("async");
      step();
      reset = 1'b0;
      m_pc  = 32'h0;
      m_ret = 16'h0;

      pulse_start();
      issue(32'h40209033, 2);
      do_reset();

      // reset while awaiting ack, then a stray ack
      pulse_start();
      #2 reset = 1'b1;
      #1;
      chk("midfetch_req", imem_req, 1'b0);
      chk("midfetch_busy", busy, 1'b0);
      step();
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h002081B3;
      step();
      imem_ack   = 1'b0;
      chk("late_ack_busy", busy, 1'b0);
      chk("late_ack_req", imem_req, 1'b0);
      chk("late_ack_rw", regwrite, 1'b0);
      chk("late_ack_pc", pc, 32'h0);
      step();
      chk("late_ack_ret", retired, 16'd0);
      chk("late_ack_rs1", read_reg_num1, 5'd0);
      chk("sb_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
